// File: rtl/pipe_pkg.sv
// Shared types and defaults for the generic pipeline stage buffer.
// Holds the buffer state encoding and default widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } pipe_state_t;

    localparam int PIPE_DATA_W_DEF = 32;
    localparam int PIPE_CNT_W      = 32;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter used for the optional stage performance counters.
// Ports: clk, rst (sync, active-high), inc (count enable), cnt (value).
module pipe_sat_cnt
    import pipe_pkg::*;
#(
    parameter int W = PIPE_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic 2-entry skid buffer between pipeline stages with flush and sticky halt.
// Ports: CLK/RST, in_valid/in_ready/in_data/in_halt, flush,
//   out_valid/out_ready/out_data/out_halt, halt_sticky, occupancy.
// Build option PIPE_STAGE_BUF_PERF_EN adds stall_cnt and bubble_cnt outputs.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W     = PIPE_DATA_W_DEF,
    parameter int HALT_BLOCK = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_halt,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_halt,
    output logic              halt_sticky,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_BUF_PERF_EN
    ,
    output logic [PIPE_CNT_W-1:0] stall_cnt,
    output logic [PIPE_CNT_W-1:0] bubble_cnt
`endif
);

    localparam logic haltBlk = (HALT_BLOCK != 0);

    pipe_state_t       state;
    pipe_state_t       stateNext;
    logic [DATA_W-1:0] mainData;
    logic [DATA_W-1:0] skidData;
    logic              mainHalt;
    logic              skidHalt;
    logic              haltSeen;
    logic              push;
    logic              pop;
    logic              ldMainIn;
    logic              ldMainSkid;
    logic              ldSkid;

    // Ready depends on registered state only, so no out_ready path crosses.
    assign in_ready    = (state != FULL) && !(haltBlk && haltSeen);
    assign out_valid   = (state != EMPTY);
    assign out_data    = mainData;
    assign out_halt    = mainHalt;
    assign halt_sticky = haltSeen;
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign occupancy   = (state == FULL) ? 2'd2 :
                         (state == ONE)  ? 2'd1 : 2'd0;

    always_comb begin
        stateNext  = state;
        ldMainIn   = 1'b0;
        ldMainSkid = 1'b0;
        ldSkid     = 1'b0;
        if (flush) begin
            // Squash drops any simultaneous push.
            stateNext = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        stateNext = ONE;
                        ldMainIn  = 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        ldMainIn = 1'b1;
                    end else if (push) begin
                        stateNext = FULL;
                        ldSkid    = 1'b1;
                    end else if (pop) begin
                        stateNext = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        stateNext  = ONE;
                        ldMainSkid = 1'b1;
                    end
                end
                default: stateNext = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= EMPTY;
            mainData <= '0;
            mainHalt <= 1'b0;
            skidData <= '0;
            skidHalt <= 1'b0;
            haltSeen <= 1'b0;
        end else begin
            state <= stateNext;
            if (ldMainIn) begin
                mainData <= in_data;
                mainHalt <= in_halt;
            end else if (ldMainSkid) begin
                mainData <= skidData;
                mainHalt <= skidHalt;
            end
            if (ldSkid) begin
                skidData <= in_data;
                skidHalt <= in_halt;
            end
            // A pop during flush still retires the head.
            if (pop && mainHalt) begin
                haltSeen <= 1'b1;
            end
        end
    end

`ifdef PIPE_STAGE_BUF_PERF_EN
    pipe_sat_cnt #(.W(PIPE_CNT_W)) uStallCnt (
        .clk (CLK),
        .rst (RST),
        .inc (in_valid && !in_ready),
        .cnt (stall_cnt)
    );

    pipe_sat_cnt #(.W(PIPE_CNT_W)) uBubbleCnt (
        .clk (CLK),
        .rst (RST),
        .inc (!out_valid && !haltSeen),
        .cnt (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Testbench for pipe_stage_buf: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_pipe_stage_buf;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_halt;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_halt;
    logic        halt_sticky;
    logic [1:0]  occupancy;
`ifdef PIPE_STAGE_BUF_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
`endif

    pipe_stage_buf #(.DATA_W(32), .HALT_BLOCK(1)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_halt     (in_halt),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_halt    (out_halt),
        .halt_sticky (halt_sticky),
        .occupancy   (occupancy)
`ifdef PIPE_STAGE_BUF_PERF_EN
        ,
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] d;
        logic        h;
    } entry_t;

    entry_t      sb[$];
    entry_t      e;
    logic        mSticky = 1'b0;
    logic        mReady;
    logic [31:0] mStall  = 0;
    logic [31:0] mBubble = 0;
    int          total   = 0;
    int          bad     = 0;
    int          cycles  = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h",
                     nm, cycles, act, exp);
        end
    endtask

    // Monitor + reference model: inputs are stable at the falling edge,
    // so compare outputs, then advance the model by the coming rising edge.
    always @(negedge CLK) begin
        cycles++;
        mReady = (sb.size() < 2) && !mSticky;
        check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        check("occupancy", 32'(occupancy), 32'(sb.size()));
        check("in_ready", 32'(in_ready), 32'(mReady));
        check("halt_sticky", 32'(halt_sticky), 32'(mSticky));
        if (sb.size() != 0) begin
            check("out_data", out_data, sb[0].d);
            check("out_halt", 32'(out_halt), 32'(sb[0].h));
        end
`ifdef PIPE_STAGE_BUF_PERF_EN
        check("stall_cnt", stall_cnt, mStall);
        check("bubble_cnt", bubble_cnt, mBubble);
`endif
        if (RST) begin
            sb.delete();
            mSticky = 1'b0;
            mStall  = 0;
            mBubble = 0;
        end else begin
            if (in_valid && !mReady && mStall != 32'hFFFF_FFFF)
                mStall++;
            if (sb.size() == 0 && !mSticky && mBubble != 32'hFFFF_FFFF)
                mBubble++;
            if (sb.size() != 0 && out_ready) begin
                e = sb.pop_front();
                if (e.h) mSticky = 1'b1;
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && mReady) begin
                e.d = in_data;
                e.h = in_halt;
                sb.push_back(e);
            end
        end
    end

    task automatic drive(input logic r, input logic v, input logic [31:0] d,
                         input logic h, input logic fl, input logic ordy);
        RST       = r;
        in_valid  = v;
        in_data   = d;
        in_halt   = h;
        flush     = fl;
        out_ready = ordy;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; in_valid = 0; in_data = 0; in_halt = 0;
        flush = 0; out_ready = 0;
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);

        // streaming
        drive(0, 1, 32'hDEADBEEF, 0, 0, 1);
        drive(0, 1, 32'h1, 0, 0, 1);
        drive(0, 1, 32'h2, 0, 0, 1);
        drive(0, 1, 32'h3, 0, 0, 1);
        drive(0, 0, 32'h0, 0, 0, 1);
        drive(0, 0, 32'h0, 0, 0, 1);

        // backpressure: A, B accepted, C refused
        drive(0, 1, 32'hA, 0, 0, 0);
        drive(0, 1, 32'hB, 0, 0, 0);
        drive(0, 1, 32'hC, 0, 0, 0);
        drive(0, 1, 32'hC, 0, 0, 0);
        drive(0, 0, 32'h0, 0, 0, 1);
        drive(0, 0, 32'h0, 0, 0, 1);
        drive(0, 0, 32'h0, 0, 0, 1);

        // flush while full with a simultaneous push
        drive(0, 1, 32'hA, 0, 0, 0);
        drive(0, 1, 32'hB, 0, 0, 0);
        drive(0, 1, 32'hC, 0, 1, 0);
        drive(0, 0, 32'h0, 0, 0, 1);
        drive(0, 0, 32'h0, 0, 0, 1);

        // halt retires, blocks intake, survives flush, cleared by reset
        drive(0, 1, 32'h5, 1, 0, 1);
        drive(0, 0, 32'h0, 0, 0, 1);
        drive(0, 1, 32'h7, 0, 0, 1);
        drive(0, 1, 32'h8, 0, 1, 1);
        drive(0, 1, 32'h9, 0, 0, 1);
        drive(1, 0, 32'h0, 0, 0, 0);
        drive(0, 0, 32'h0, 0, 0, 0);

        // hold with toggling input, then reset while full
        drive(0, 1, 32'h1234, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            drive(0, 1, $urandom, 0, 0, 0);
        drive(1, 1, 32'h55, 0, 0, 0);
        drive(0, 0, 32'h0, 0, 0, 0);

        // counters: 4 empty cycles, then 3 refused pushes
        drive(1, 0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            drive(0, 0, 32'h0, 0, 0, 0);
        drive(0, 1, 32'h11, 0, 0, 0);
        drive(0, 1, 32'h22, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            drive(0, 1, 32'h33, 0, 0, 0);
        drive(0, 0, 32'h0, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 149) == 0),
                  ($urandom_range(0, 9) < 7),
                  $urandom,
                  ($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) < 6));
        end
        drive(0, 0, 32'h0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
